// File: rtl/axi_lite_regbank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
//   w_state_t / r_state_t : write and read channel FSM states
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   clog2 : elaboration-time ceiling log2 used for address decode widths
package axi_lite_regbank_pkg;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_regbank_rd_ch.sv
// AXI4-Lite read channel of the register bank.
//   clk, rst_n        : clock, asynchronous active-low reset
//   araddr/arprot/arvalid/arready : AR channel (arprot ignored)
//   rdata/rresp/rvalid/rready     : R channel
//   reg_out           : flat RW register contents from the write side
//   reg_in            : flat status inputs, used for read-only registers
//   rd_pulse          : one-cycle strobe per register on an in-range AR handshake
module axi_lite_regbank_rd_ch
  import axi_lite_regbank_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_NUM_REGS         = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            araddr,
  input  logic [2:0]                               arprot,
  input  logic                                     arvalid,
  output logic                                     arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                               rresp,
  output logic                                     rvalid,
  input  logic                                     rready,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [C_NUM_REGS-1:0]                    rd_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned ADDR_LSB = clog2(DW / 8);
  localparam int unsigned IDX_W    = clog2(C_NUM_REGS);

  r_state_t          r_state;
  logic              ready_en;
  logic              ar_hs;
  logic [IDX_W-1:0]  ar_idx;
  logic              ar_oor;
  logic [DW-1:0]     rd_word;
  int unsigned       rd_base;
  logic              unused_rd;

  // Ready flags stay low through reset and rise on the first edge after it.
  assign arready = ready_en && (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign ar_hs   = arvalid && arready;

  assign ar_idx  = araddr[ADDR_LSB +: IDX_W];
  assign ar_oor  = |(araddr >> (ADDR_LSB + IDX_W));
  assign unused_rd = ^{arprot, araddr[ADDR_LSB-1:0]};

  always_comb begin
    rd_word = '0;
    rd_base = 32'(ar_idx) * DW;
    if (!ar_oor) begin
      if (C_RO_MASK[ar_idx]) rd_word = reg_in[rd_base +: DW];
      else                   rd_word = reg_out[rd_base +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      ready_en <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      rd_pulse <= '0;
    end else begin
      ready_en <= 1'b1;
      rd_pulse <= '0;
      if (r_state == R_IDLE) begin
        if (ar_hs) begin
          rdata   <= rd_word;
          rresp   <= ar_oor ? RESP_SLVERR : RESP_OKAY;
          if (!ar_oor) rd_pulse[ar_idx] <= 1'b1;
          r_state <= R_RESP;
        end
      end else if (rready) begin
        r_state <= R_IDLE;
      end
    end
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with byte-strobed RW registers and
// read-only status registers (selected by C_RO_MASK, sourced from reg_in).
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*         : write address, data and response channels
//   s00_axi_ar* / r*              : read address and data channels
//   reg_out  : flat register contents, register n at [n*DW +: DW]
//   reg_in   : flat status values for read-only registers
//   wr_pulse : one-cycle strobe coincident with a register update
//   rd_pulse : one-cycle strobe on an in-range read address handshake
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_NUM_REGS         = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
  input  logic                                     s00_axi_aclk,
  input  logic                                     s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_awaddr,
  input  logic [2:0]                               s00_axi_awprot,
  input  logic                                     s00_axi_awvalid,
  output logic                                     s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s00_axi_wstrb,
  input  logic                                     s00_axi_wvalid,
  output logic                                     s00_axi_wready,
  output logic [1:0]                               s00_axi_bresp,
  output logic                                     s00_axi_bvalid,
  input  logic                                     s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_araddr,
  input  logic [2:0]                               s00_axi_arprot,
  input  logic                                     s00_axi_arvalid,
  output logic                                     s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_rdata,
  output logic [1:0]                               s00_axi_rresp,
  output logic                                     s00_axi_rvalid,
  input  logic                                     s00_axi_rready,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [C_NUM_REGS-1:0]                    wr_pulse,
  output logic [C_NUM_REGS-1:0]                    rd_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB       = DW / 8;
  localparam int unsigned ADDR_LSB = clog2(NB);
  localparam int unsigned IDX_W    = clog2(C_NUM_REGS);

  w_state_t          w_state;
  logic              ready_en;
  logic              aw_hs;
  logic              w_hs;
  logic [IDX_W-1:0]  aw_idx_in;
  logic              aw_oor_in;
  logic [IDX_W-1:0]  aw_idx_q;
  logic              aw_oor_q;
  logic [DW-1:0]     w_data_q;
  logic [NB-1:0]     w_strb_q;
  logic [1:0]        bresp_q;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_oor;
  logic [DW-1:0]     cur_data;
  logic [NB-1:0]     cur_strb;
  logic              do_write;
  logic              wr_ok;
  logic [DW-1:0]     regs [C_NUM_REGS];
  logic              unused_wr;

  assign s00_axi_awready = ready_en && (w_state == W_IDLE || w_state == W_HAVE_DATA);
  assign s00_axi_wready  = ready_en && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
  assign s00_axi_bvalid  = (w_state == W_RESP);
  assign s00_axi_bresp   = bresp_q;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;

  assign aw_idx_in = s00_axi_awaddr[ADDR_LSB +: IDX_W];
  assign aw_oor_in = |(s00_axi_awaddr >> (ADDR_LSB + IDX_W));
  assign unused_wr = ^{s00_axi_awprot, s00_axi_awaddr[ADDR_LSB-1:0]};

  // The write commits on the cycle the second half arrives, so the live
  // channel value is used for whichever half is handshaking right now.
  always_comb begin
    cur_idx  = aw_hs ? aw_idx_in : aw_idx_q;
    cur_oor  = aw_hs ? aw_oor_in : aw_oor_q;
    cur_data = w_hs ? s00_axi_wdata : w_data_q;
    cur_strb = w_hs ? s00_axi_wstrb : w_strb_q;
    unique case (w_state)
      W_IDLE:      do_write = aw_hs && w_hs;
      W_HAVE_ADDR: do_write = w_hs;
      W_HAVE_DATA: do_write = aw_hs;
      default:     do_write = 1'b0;
    endcase
    wr_ok = !cur_oor && !C_RO_MASK[cur_idx];
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state  <= W_IDLE;
      ready_en <= 1'b0;
      aw_idx_q <= '0;
      aw_oor_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_idx_q <= aw_idx_in;
        aw_oor_q <= aw_oor_in;
      end
      if (w_hs) begin
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end
      if (do_write) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        w_state <= W_RESP;
      end else begin
        unique case (w_state)
          W_IDLE: begin
            if (aw_hs)     w_state <= W_HAVE_ADDR;
            else if (w_hs) w_state <= W_HAVE_DATA;
          end
          W_RESP:  if (s00_axi_bready) w_state <= W_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int unsigned n = 0; n < C_NUM_REGS; n++) regs[n] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (do_write && wr_ok && (|cur_strb)) begin
        wr_pulse[cur_idx] <= 1'b1;
        for (int unsigned b = 0; b < NB; b++) begin
          if (cur_strb[b]) regs[cur_idx][b*8 +: 8] <= cur_data[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned n = 0; n < C_NUM_REGS; n++) reg_out[n*DW +: DW] = regs[n];
  end

  axi_lite_regbank_rd_ch #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .C_NUM_REGS         (C_NUM_REGS),
    .C_RO_MASK          (C_RO_MASK)
  ) u_rd_ch (
    .clk      (s00_axi_aclk),
    .rst_n    (s00_axi_aresetn),
    .araddr   (s00_axi_araddr),
    .arprot   (s00_axi_arprot),
    .arvalid  (s00_axi_arvalid),
    .arready  (s00_axi_arready),
    .rdata    (s00_axi_rdata),
    .rresp    (s00_axi_rresp),
    .rvalid   (s00_axi_rvalid),
    .rready   (s00_axi_rready),
    .reg_out  (reg_out),
    .reg_in   (reg_in),
    .rd_pulse (rd_pulse)
  );

endmodule

// File: tb/tb_axi_lite_regbank.sv
module tb_axi_lite_regbank;

  localparam logic [7:0] RO_MASK = 8'h80;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  logic         clk;
  logic         rst_n;
  logic [11:0]  awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [11:0]  araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [255:0] reg_out;
  logic [255:0] reg_in;
  logic [7:0]   wr_pulse;
  logic [7:0]   rd_pulse;

  int total;
  int bad;

  logic [31:0] model_regs [8];
  int          exp_wr [8];
  int          exp_rd [8];
  int          wr_cnt [8];
  int          rd_cnt [8];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [33:0] mon_e;

  axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (12),
    .C_NUM_REGS         (8),
    .C_RO_MASK          (RO_MASK)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg_out         (reg_out),
    .reg_in          (reg_in),
    .wr_pulse        (wr_pulse),
    .rd_pulse        (rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference write: register index is the byte address divided by 4;
  // indices 8 and up are out of range, read-only targets reject the write.
  task automatic model_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (idx >= 8 || RO_MASK[idx]) begin
      resp = SLVERR;
    end else begin
      resp = OKAY;
      if (s != 4'b0) exp_wr[idx]++;
      for (int b = 0; b < 4; b++)
        if (s[b]) model_regs[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic wait_b_resp();
    int cyc;
    cyc = 0;
    while (!(bvalid && bready)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 50) begin fail_now("b_timeout"); return; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_r_resp();
    int cyc;
    cyc = 0;
    while (!(rvalid && rready)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 50) begin fail_now("r_timeout"); return; end
    end
    @(posedge clk); #1;
  endtask

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input bit wait_b);
    logic [1:0] r;
    bit aw_done, w_done, aw_h, w_h;
    int cyc;
    model_write(a, d, s, r);
    exp_b.push_back(r);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = (lead <= 0);
    wvalid  = (lead >= 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      if ((aw_done || aw_h) && (w_done || w_h)) check("b_early", 64'(bvalid), 64'd0);
      @(posedge clk); #1;
      if (aw_h) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_h)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      cyc++;
      if (!aw_done && cyc >= lead)  awvalid = 1'b1;
      if (!w_done  && cyc >= -lead) wvalid  = 1'b1;
      if (!(aw_done && w_done) && cyc > 50) begin
        fail_now("aw_w_timeout");
        awvalid = 1'b0;
        wvalid  = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check("b_latency", 64'(bvalid), 64'd1);
    if (wait_b) wait_b_resp();
    else begin @(posedge clk); #1; end
  endtask

  task automatic do_read_exp(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er,
                             input bit wait_r);
    bit hs;
    int cyc;
    exp_r.push_back({er, ed});
    if (int'(a) / 4 < 8) exp_rd[int'(a) / 4]++;
    araddr  = a;
    arvalid = 1'b1;
    hs      = 1'b0;
    cyc     = 0;
    while (!hs) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
      if (!hs && cyc > 50) begin fail_now("ar_timeout"); arvalid = 1'b0; return; end
    end
    arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", 64'(rvalid), 64'd1);
    if (wait_r) wait_r_resp();
    else begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input logic [11:0] a, input bit wait_r);
    int idx;
    idx = int'(a) / 4;
    if (idx >= 8)          do_read_exp(a, 32'h0, SLVERR, wait_r);
    else if (RO_MASK[idx]) do_read_exp(a, reg_in[idx*32 +: 32], OKAY, wait_r);
    else                   do_read_exp(a, model_regs[idx], OKAY, wait_r);
  endtask

  // Scoreboard monitor: pops an expectation at every response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin
          mon_e = exp_r.pop_front();
          check("rresp", 64'(rresp), 64'(mon_e[33:32]));
          check("rdata", 64'(rdata), 64'(mon_e[31:0]));
        end
      end
      for (int n = 0; n < 8; n++) begin
        if (wr_pulse[n]) wr_cnt[n]++;
        if (rd_pulse[n]) rd_cnt[n]++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pre;
    logic [11:0] ra;
    logic [31:0] rd;
    logic [3:0]  rs;
    int          lead;
    int unsigned op;

    total = 0;
    bad   = 0;
    for (int n = 0; n < 8; n++) begin
      model_regs[n] = '0;
      exp_wr[n] = 0; exp_rd[n] = 0; wr_cnt[n] = 0; rd_cnt[n] = 0;
    end
    awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b1;
    reg_in = '0;
    reg_in[7*32 +: 32] = 32'hCAFE0001;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_regout",  64'(|reg_out), 64'd0);
    #18 rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(awready), 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge_aw", 64'(awready), 64'd1);
    check("ready_after_edge_w",  64'(wready),  64'd1);
    check("ready_after_edge_ar", 64'(arready), 64'd1);

    // Basic writes then readback.
    for (int i = 0; i < 4; i++) do_write(12'(i * 4), 32'(i + 1), 4'hF, 0, 1'b1);
    for (int i = 0; i < 4; i++) do_read(12'(i * 4), 1'b1);

    // Byte-strobe merge.
    do_write(12'h004, 32'h11223344, 4'hF, 0, 1'b1);
    do_write(12'h004, 32'hAABBCCDD, 4'b0101, 0, 1'b1);
    check("strobe_merge", 64'(reg_out[1*32 +: 32]), 64'h11BB33DD);
    do_read(12'h004, 1'b1);

    // Channel ordering: W well ahead, same cycle, AW ahead.
    do_write(12'h008, 32'h0BADCAFE, 4'hF, 3, 1'b1);
    do_write(12'h00C, 32'h12345678, 4'hF, 0, 1'b1);
    do_write(12'h010, 32'h87654321, 4'hF, -2, 1'b1);

    // Error targets, zero strobe, read-only and out-of-range reads.
    do_write(12'h020, 32'hFFFFFFFF, 4'hF, 0, 1'b1);
    do_write(12'h01C, 32'hFFFFFFFF, 4'hF, 1, 1'b1);
    check("ro_unchanged", 64'(reg_out[7*32 +: 32]), 64'd0);
    do_write(12'h014, 32'h55555555, 4'h0, 0, 1'b1);
    do_read(12'h01C, 1'b1);
    do_read(12'h020, 1'b1);
    do_read(12'h3FC, 1'b1);

    // Simultaneous read and write of one register returns the old value.
    pre = model_regs[2];
    fork
      do_write(12'h008, 32'h600DF00D, 4'hF, 0, 1'b1);
      do_read_exp(12'h008, pre, OKAY, 1'b1);
    join

    // Back-pressure on both response channels.
    bready = 1'b0;
    rready = 1'b0;
    do_write(12'h018, 32'h5A5A0F0F, 4'hF, 0, 1'b0);
    do_read(12'h00C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_bvalid",  64'(bvalid),  64'd1);
      check("stall_bresp",   64'(bresp),   64'(OKAY));
      check("stall_rvalid",  64'(rvalid),  64'd1);
      check("stall_rdata",   64'(rdata),   64'(model_regs[3]));
      check("stall_awready", 64'(awready), 64'd0);
      check("stall_wready",  64'(wready),  64'd0);
      check("stall_arready", 64'(arready), 64'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    rready = 1'b1;
    fork
      wait_b_resp();
      wait_r_resp();
    join

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 2);
      ra   = 12'($urandom_range(0, 39));
      rd   = $urandom();
      rs   = 4'($urandom_range(0, 15));
      lead = int'($urandom_range(0, 6)) - 3;
      if (op == 0) begin
        reg_in[7*32 +: 32] = $urandom();
        do_read(ra, 1'b1);
      end else begin
        do_write(ra, rd, rs, lead, 1'b1);
      end
    end

    for (int n = 0; n < 8; n++) check("regout_final", 64'(reg_out[n*32 +: 32]), 64'(model_regs[n]));

    // Reset after AW accepted but before W.
    do_write(12'h014, 32'hA5A5A5A5, 4'hF, 0, 1'b1);
    awaddr  = 12'h014;
    awvalid = 1'b1;
    begin
      bit hs;
      int cyc;
      hs = 1'b0;
      cyc = 0;
      while (!hs && cyc <= 50) begin
        @(negedge clk);
        hs = awvalid && awready;
        @(posedge clk); #1;
        cyc++;
      end
      if (!hs) fail_now("rst_aw_timeout");
    end
    awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bvalid",  64'(bvalid),  64'd0);
    check("midrst_rvalid",  64'(rvalid),  64'd0);
    check("midrst_awready", 64'(awready), 64'd0);
    check("midrst_wready",  64'(wready),  64'd0);
    check("midrst_arready", 64'(arready), 64'd0);
    check("midrst_regout",  64'(|reg_out), 64'd0);
    for (int n = 0; n < 8; n++) model_regs[n] = '0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(12'h014, 1'b1);

    for (int n = 0; n < 8; n++) begin
      check("wr_pulse_count", 64'(wr_cnt[n]), 64'(exp_wr[n]));
      check("rd_pulse_count", 64'(rd_cnt[n]), 64'(exp_rd[n]));
    end
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    check("r_queue_empty", 64'(exp_r.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
